// File: rtl/granule_stage_sequencer_pkg.sv
// Shared decoder package for the granule stage sequencer.
//
// Holds the sequencer state encoding, the default frame geometry
// (stages per granule, granules per frame) and the fixed stage index
// constants of the decoder pipeline.
package granule_stage_sequencer_pkg;

  // Default frame geometry.
  localparam int NUM_STAGES_DFLT   = 5;
  localparam int NUM_GRANULES_DFLT = 2;

  // Width of a stage index. This is also the width of ram_owner.
  localparam int STAGE_W = 3;

  // Decoder stage indices, in processing order.
  localparam logic [STAGE_W-1:0] STG_REQUANT   = 3'd0;
  localparam logic [STAGE_W-1:0] STG_STEREO    = 3'd1;
  localparam logic [STAGE_W-1:0] STG_REORDER   = 3'd2;
  localparam logic [STAGE_W-1:0] STG_ANTIALIAS = 3'd3;
  localparam logic [STAGE_W-1:0] STG_IMDCT     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ABORT   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/granule_stage_sequencer_stage_watchdog.sv
// stage_watchdog: per-stage activity watchdog for the granule sequencer.
//
// The count shows the number of cycles since the stage's start pulse.
// It saturates at TIMEOUT and never wraps.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (count -> 0)
//   load    in   reload the count with 0 (takes priority over enable)
//   enable  in   advance the count by one (saturating)
//   expired out  high when the next increment would reach TIMEOUT
module stage_watchdog #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire one count early. The sequencer acts on this flag at the clock
  // edge that would take the count to TIMEOUT. As a result, the abort state
  // begins exactly TIMEOUT cycles after the start pulse.
  assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/granule_stage_sequencer.sv
// granule_stage_sequencer: sequences the per-granule decoder stages.
//
// For each granule of a frame, the stages run in the order 0..NUM_STAGES-1.
// Each stage gets a one-cycle start pulse and then has up to TIMEOUT cycles
// to answer with its done bit. If a stage does not answer in time, the frame
// is aborted and a sticky error is raised.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   frame_start  in   one-cycle request to process one frame
//   stage_done   in   per-stage completion, bit i from stage i
//   stage_ready  out  per-stage one-cycle start pulse
//   ram_owner    out  stage index owning the granule RAM port muxes
//   granule_idx  out  current granule number
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse when the frame completes
//   timeout_err  out  sticky abort flag, cleared by the next accepted start
module granule_stage_sequencer
  import granule_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES   = NUM_STAGES_DFLT,
  parameter int NUM_GRANULES = NUM_GRANULES_DFLT,
  parameter int TIMEOUT      = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_ready,
  output logic [STAGE_W-1:0]    ram_owner,
  output logic                  granule_idx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err
);

  localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_STAGES - 1);
  localparam logic               LAST_GRANULE = 1'(NUM_GRANULES - 1);

  seq_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               granule_q, granule_d;
  logic               terr_q, terr_d;

  logic               done_sel;
  logic               wd_load;
  logic               wd_en;
  logic               wd_expired;

  // Only the active stage's done bit is considered. Done bits from other
  // stages never reach the FSM.
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STAGE_W'(i)) begin
        done_sel = stage_done[i];
      end
    end
  end

  // The watchdog is reloaded in every state that precedes a LAUNCH, so it
  // reads 0 during the start pulse. It then counts through LAUNCH and WAIT.
  always_comb begin
    wd_load = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      ST_LAUNCH, ST_WAIT: wd_en   = 1'b1;
      default:            wd_load = 1'b1;
    endcase
  end

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    granule_d = granule_q;
    terr_d    = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_LAUNCH;
          stage_d   = STG_REQUANT;
          granule_d = 1'b0;
          terr_d    = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // If done and expiry arrive together, done takes priority.
        if (done_sel) begin
          state_d = ST_ADVANCE;
        end else if (wd_expired) begin
          state_d = ST_ABORT;
          terr_d  = 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (stage_q < LAST_STAGE) begin
          stage_d = stage_q + STAGE_W'(1);
          state_d = ST_LAUNCH;
        end else begin
          stage_d = STG_REQUANT;
          if (granule_q < LAST_GRANULE) begin
            granule_d = granule_q + 1'b1;
            state_d   = ST_LAUNCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        stage_d   = STG_REQUANT;
        granule_d = 1'b0;
      end
      ST_ABORT: begin
        state_d   = ST_IDLE;
        stage_d   = STG_REQUANT;
        granule_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        stage_d   = STG_REQUANT;
        granule_d = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      granule_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      granule_q <= granule_d;
      terr_q    <= terr_d;
    end
  end

  // Moore outputs, decoded from registered state only.
  always_comb begin
    stage_ready = '0;
    ram_owner   = '0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_LAUNCH: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          stage_ready[i] = (stage_q == STAGE_W'(i));
        end
        ram_owner = stage_q;
        busy      = 1'b1;
      end
      ST_WAIT, ST_ADVANCE: begin
        ram_owner = stage_q;
        busy      = 1'b1;
      end
      ST_FINISH: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign granule_idx = granule_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_granule_stage_sequencer.sv
// Directed testbench for granule_stage_sequencer (NUM_STAGES=5, NUM_GRANULES=2, TIMEOUT=16).
module tb_granule_stage_sequencer;

  localparam int NS = 5;
  localparam int NG = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_ready;
  logic [2:0]    ram_owner;
  logic          granule_idx;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [NS-1:0] ready_log[$];
  int            done_cnt = 0;

  always #5 clk = ~clk;

  granule_stage_sequencer #(
    .NUM_STAGES   (NS),
    .NUM_GRANULES (NG),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .stage_done  (stage_done),
    .stage_ready (stage_ready),
    .ram_owner   (ram_owner),
    .granule_idx (granule_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  // Record every start pulse and every frame_done pulse.
  always @(negedge clk) begin
    if (stage_ready != '0) ready_log.push_back(stage_ready);
    if (frame_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(stage_ready), 32'd0);
    check({tag, "_owner"}, 32'(ram_owner), 32'd0);
    check({tag, "_gran"},  32'(granule_idx), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_terr"},  32'(timeout_err), 32'd0);
  endtask

  // Entered during stage s's start-pulse cycle. Answers with done d cycles
  // after the pulse and returns two cycles later, i.e. in the next LAUNCH
  // (or FINISH) cycle. On the second wait cycle it optionally drives a
  // spurious done mask and/or a frame_start pulse.
  task automatic answer(input int s, input int d, input logic [NS-1:0] spur, input logic poke);
    for (int k = 1; k <= d; k++) begin
      cyc();
      check("wait_owner", 32'(ram_owner), 32'(s));
      check("wait_ready", 32'(stage_ready), 32'd0);
      check("wait_busy",  32'(busy), 32'd1);
      stage_done  = '0;
      frame_start = 1'b0;
      if (k == d) begin
        stage_done = NS'(1) << s;
      end else if (k == 2) begin
        stage_done  = spur;
        frame_start = poke;
      end
    end
    cyc();
    stage_done  = '0;
    frame_start = 1'b0;
    check("adv_owner", 32'(ram_owner), 32'(s));
    check("adv_ready", 32'(stage_ready), 32'd0);
    cyc();
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    stage_done  = '0;
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b0;
    cyc();
    check_all_zero("idle");

    // Normal frame, done 10 cycles after each ready. A spurious done[3]
    // arrives while stage 1 of granule 0 waits, and a frame_start arrives
    // while stage 0 of granule 1 waits.
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int g = 0; g < NG; g++) begin
      for (int s = 0; s < NS; s++) begin
        check("n_ready", 32'(stage_ready), 32'(1) << s);
        check("n_gran",  32'(granule_idx), 32'(g));
        check("n_owner", 32'(ram_owner), 32'(s));
        check("n_busy",  32'(busy), 32'd1);
        answer(s, 10, (g == 0 && s == 1) ? 5'b01000 : 5'b00000, (g == 1 && s == 0));
      end
    end
    check("fin_fdone", 32'(frame_done), 32'd1);
    check("fin_busy",  32'(busy), 32'd1);
    check("fin_ready", 32'(stage_ready), 32'd0);
    check("fin_owner", 32'(ram_owner), 32'd0);
    cyc();
    check("post_fdone", 32'(frame_done), 32'd0);
    check("post_busy",  32'(busy), 32'd0);
    check("post_gran",  32'(granule_idx), 32'd0);
    check("post_terr",  32'(timeout_err), 32'd0);
    repeat (3) cyc();
    check("n_pulses", 32'(ready_log.size()), 32'd10);
    for (int i = 0; i < ready_log.size(); i++) begin
      check("n_order", 32'(ready_log[i]), 32'(1) << (i % NS));
    end
    check("n_done_cnt", 32'(done_cnt), 32'd1);

    // Held done on stage 0 for 5 cycles, after which stage 1 never answers.
    ready_log.delete();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("h_ready0", 32'(stage_ready), 32'd1);
    cyc();
    stage_done = 5'b00001;
    cyc();
    check("h_adv_owner", 32'(ram_owner), 32'd0);
    cyc();
    check("h_ready1", 32'(stage_ready), 32'd2);
    check("h_owner1", 32'(ram_owner), 32'd1);
    for (int t = 1; t < TO; t++) begin
      cyc();
      if (t == 3) stage_done = '0;
      check("to_busy",  32'(busy), 32'd1);
      check("to_terr",  32'(timeout_err), 32'd0);
      check("to_owner", 32'(ram_owner), 32'd1);
      check("to_ready", 32'(stage_ready), 32'd0);
    end
    cyc();
    check("ab_busy",  32'(busy), 32'd0);
    check("ab_terr",  32'(timeout_err), 32'd1);
    check("ab_ready", 32'(stage_ready), 32'd0);
    check("ab_owner", 32'(ram_owner), 32'd0);
    check("ab_fdone", 32'(frame_done), 32'd0);
    cyc();
    check("ab_idle_terr", 32'(timeout_err), 32'd1);
    check("ab_idle_busy", 32'(busy), 32'd0);
    repeat (5) cyc();
    check("h_pulses", 32'(ready_log.size()), 32'd2);
    check("h_first",  32'(ready_log[0]), 32'd1);
    check("h_second", 32'(ready_log[1]), 32'd2);
    check("h_done_cnt", 32'(done_cnt), 32'd1);

    // A new frame clears timeout_err. Reset is then applied in granule 1, stage 2.
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("r_terr_clr", 32'(timeout_err), 32'd0);
    check("r_ready0",   32'(stage_ready), 32'd1);
    for (int s = 0; s < NS; s++) answer(s, 1, '0, 1'b0);
    answer(0, 1, '0, 1'b0);
    answer(1, 1, '0, 1'b0);
    check("r_ready_g1s2", 32'(stage_ready), 32'd4);
    check("r_gran_g1s2",  32'(granule_idx), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (4) cyc();
    check("midrst_done_cnt", 32'(done_cnt), 32'd1);
    check("midrst_terr",     32'(timeout_err), 32'd0);
    check("midrst_busy",     32'(busy), 32'd0);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("restart_ready", 32'(stage_ready), 32'd1);
    check("restart_gran",  32'(granule_idx), 32'd0);
    check("restart_owner", 32'(ram_owner), 32'd0);
    check("restart_busy",  32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
